subtractor_serial: RTL and testbench

Parametrised, digit-serial two's-complement subtractor computing `resultado = a - b` over `DATA_WIDTH` bits, `CHUNK_WIDTH` bits per clock, with a ripple borrow carried between cycles. It has a valid/ready handshake on input and output and reports borrow, overflow, zero and negative flags. Signed or unsigned interpretation is selected per operation. It is the sequential, width-scalable successor of the fixed 5-bit combinational subtractor in the datapath library, for wide operands where a full-width carry chain does not meet timing.

---
 rtl/subtractor_pkg.sv | 28 ++
 rtl/subtractor_chunk.sv | 30 +++
 rtl/subtractor_serial.sv | 155 +++++++++++++++
 tb/tb_subtractor_serial.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_pkg.sv
// ---------------------------------------------------------------------------
// subtractor_pkg
// Shared types for the digit-serial subtractor:
//   state_t / ST_*  : controller state encoding (IDLE, BUSY, DONE)
//   flags_t         : packed result flags {borrow, overflow, zero, negative}
//   idx_width()     : chunk-counter width, never below one bit
// ---------------------------------------------------------------------------
package subtractor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    typedef struct packed {
        logic borrow;
        logic overflow;
        logic zero;
        logic negative;
    } flags_t;

    // A single-chunk configuration still needs a one-bit counter to stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/subtractor_chunk.sv
// ---------------------------------------------------------------------------
// subtractor_chunk
// Combinational CHUNK_WIDTH-bit subtract with borrow: diff = x - y - bin.
// Ports:
//   x, y  in  CHUNK_WIDTH  minuend / subtrahend slice
//   bin   in  1            borrow-in from the previous (lower) chunk
//   diff  out CHUNK_WIDTH  difference slice
//   bout  out 1            borrow-out to the next (higher) chunk
// ---------------------------------------------------------------------------
module subtractor_chunk #(
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic [CHUNK_WIDTH-1:0] x,
    input  logic [CHUNK_WIDTH-1:0] y,
    input  logic                   bin,
    output logic [CHUNK_WIDTH-1:0] diff,
    output logic                   bout
);

    // One extra bit catches the borrow: it goes high when the true difference is negative.
    logic [CHUNK_WIDTH:0] full;

    always_comb begin
        full = {1'b0, x} - {1'b0, y} - {{CHUNK_WIDTH{1'b0}}, bin};
    end

    assign diff = full[CHUNK_WIDTH-1:0];
    assign bout = full[CHUNK_WIDTH];

endmodule

// File: rtl/subtractor_serial.sv
// ---------------------------------------------------------------------------
// subtractor_serial
// Digit-serial two's-complement subtractor: resultado = a - b over DATA_WIDTH
// bits, CHUNK_WIDTH bits per clock, borrow rippled between cycles through a
// single reused subtractor_chunk.
// Ports:
//   clk, rst     single clock, asynchronous active-high reset
//   in_valid     operands valid            in_ready   accepting (IDLE only)
//   a, b         operands, sampled on accept
//   signed_mode  1 = signed flags, sampled on accept
//   out_valid    result/flags valid        out_ready  consumer accepts
//   resultado    a - b mod 2^DATA_WIDTH
//   borrow, overflow, zero, negative  registered result flags
// ---------------------------------------------------------------------------
module subtractor_serial
    import subtractor_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned CHUNK_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] resultado,
    output logic                  borrow,
    output logic                  overflow,
    output logic                  zero,
    output logic                  negative
);

    localparam int unsigned NumChunks = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned IdxW      = idx_width(NumChunks);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumChunks - 1);

    if ((DATA_WIDTH % CHUNK_WIDTH) != 0) begin : gen_bad_cfg
        $error("subtractor_serial: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    // Operands and result viewed as arrays of chunks so the chunk index is a plain mux select.
    typedef logic [NumChunks-1:0][CHUNK_WIDTH-1:0] chunks_t;

    state_t            state_q, state_d;
    chunks_t           a_q, a_d;
    chunks_t           b_q, b_d;
    chunks_t           res_q, res_d;
    logic              sm_q, sm_d;
    logic              bor_q, bor_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    flags_t            flags_q, flags_d;

    logic [CHUNK_WIDTH-1:0] chunk_diff;
    logic                   chunk_bout;

    subtractor_chunk #(
        .CHUNK_WIDTH(CHUNK_WIDTH)
    ) u_chunk (
        .x    (a_q[idx_q]),
        .y    (b_q[idx_q]),
        .bin  (bor_q),
        .diff (chunk_diff),
        .bout (chunk_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sm_d    = sm_q;
        bor_d   = bor_q;
        idx_d   = idx_q;
        flags_d = flags_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    bor_d   = 1'b0;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                res_d[idx_q] = chunk_diff;
                bor_d        = chunk_bout;
                idx_d        = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = ST_DONE;
                    // Flags use res_d so the chunk written on this edge is included.
                    flags_d.borrow   = chunk_bout;
                    flags_d.overflow = sm_q
                                     & (a_q[NumChunks-1][CHUNK_WIDTH-1]
                                        != b_q[NumChunks-1][CHUNK_WIDTH-1])
                                     & (res_d[NumChunks-1][CHUNK_WIDTH-1]
                                        != a_q[NumChunks-1][CHUNK_WIDTH-1]);
                    flags_d.zero     = (res_d == '0);
                    flags_d.negative = sm_q ? res_d[NumChunks-1][CHUNK_WIDTH-1] : chunk_bout;
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sm_q    <= 1'b0;
            bor_q   <= 1'b0;
            idx_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sm_q    <= sm_d;
            bor_q   <= bor_d;
            idx_q   <= idx_d;
            flags_q <= flags_d;
        end
    end

    // Pure state decodes: no combinational path from in_valid or out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    assign resultado = res_q;
    assign borrow    = flags_q.borrow;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;
    assign negative  = flags_q.negative;

endmodule

// File: tb/tb_subtractor_serial.sv
module tb_subtractor_serial;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;
    localparam int unsigned N  = DW / CW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] a = '0;
    logic [DW-1:0] b = '0;
    logic          signed_mode = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] resultado;
    logic          borrow, overflow, zero, negative;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    subtractor_serial #(
        .DATA_WIDTH (DW),
        .CHUNK_WIDTH(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .signed_mode(signed_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .resultado  (resultado),
        .borrow     (borrow),
        .overflow   (overflow),
        .zero       (zero),
        .negative   (negative)
    );

    // Reference: plain integer arithmetic. Flags packed as {borrow, overflow, zero, negative}.
    function automatic void model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic sm,
                                  output logic [DW-1:0] r, output logic [3:0] f);
        int          sx, sy, sd;
        logic        bo, ov, z, ng;
        int unsigned ux, uy;
        ux = x;
        uy = y;
        r  = DW'((ux + 32'h0001_0000 - uy) & 32'h0000_FFFF);
        bo = (ux < uy);
        sx = $signed(x);
        sy = $signed(y);
        sd = sx - sy;
        ov = sm && ((sd > 32767) || (sd < -32768));
        z  = (r == 0);
        ng = sm ? (sd < 0) != ov : bo;
        f  = {bo, ov, z, ng};
    endfunction

    function automatic logic [DW-1:0] pick_operand();
        logic [DW-1:0] corner [5];
        corner = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h0001};
        if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
        return DW'($urandom);
    endfunction

    // Stimulus driver only: runs one operation, reports what the DUT produced.
    task automatic do_op(input logic [DW-1:0] op_a, input logic [DW-1:0] op_b, input logic sm,
                         input int stall, output logic [DW-1:0] r, output logic [3:0] f,
                         output int lat);
        @(negedge clk);
        a           = op_a;
        b           = op_b;
        signed_mode = sm;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r = resultado;
        f = {borrow, overflow, zero, negative};
        repeat (stall) begin
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_checks++;
        if ({resultado, borrow, overflow, zero, negative} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got %h/%b%b%b%b want 0", resultado, borrow, overflow,
                     zero, negative);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [DW-1:0] ta [5];
        logic [DW-1:0] tb [5];
        logic          ts [5];
        logic [DW-1:0] tr [5];
        logic [3:0]    tf [5];
        logic [DW-1:0] r;
        logic [3:0]    f;
        int            lat;
        ta = '{16'h1234, 16'h0000, 16'h8000, 16'h7FFF, 16'hABCD};
        tb = '{16'h0034, 16'h0001, 16'h0001, 16'hFFFF, 16'hABCD};
        ts = '{1'b0,     1'b0,     1'b1,     1'b1,     1'b0};
        tr = '{16'h1200, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0000};
        tf = '{4'b0000,  4'b1001,  4'b0100,  4'b1101,  4'b0010};
        for (int i = 0; i < 5; i++) begin
            do_op(ta[i], tb[i], ts[i], 0, r, f, lat);
            n_checks++;
            if (r !== tr[i]) begin
                n_fail++;
                $display("FAIL directed_result[%0d] got %h want %h", i, r, tr[i]);
            end
            n_checks++;
            if (f !== tf[i]) begin
                n_fail++;
                $display("FAIL directed_flags[%0d] got %b want %b", i, f, tf[i]);
            end
            n_checks++;
            if (lat !== int'(N)) begin
                n_fail++;
                $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, N);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] er;
        logic [3:0]    ef;
        logic          bad_ready = 1'b0;
        logic          bad_hold  = 1'b0;
        logic          saw_valid = 1'b0;
        model(16'h4321, 16'h1234, 1'b0, er, ef);
        @(negedge clk);
        a = 16'h4321; b = 16'h1234; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (in_ready !== 1'b0) bad_ready = 1'b1;
            a = DW'($urandom); b = DW'($urandom); signed_mode = 1'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_out_valid got %b want 1", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || resultado !== er
                || {borrow, overflow, zero, negative} !== ef) bad_hold = 1'b1;
            a = DW'($urandom); b = DW'($urandom); in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bad_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_in_ready_busy got %b want 0", bad_ready);
        end
        n_checks++;
        if (bad_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_stable got %b want 0 (res %h want %h)", bad_hold, resultado, er);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release got valid/ready %b want 01", {out_valid, in_ready});
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_single_result got extra out_valid %b want 0", saw_valid);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [DW-1:0] r;
        logic [3:0]    f;
        int            lat;
        logic          saw_valid = 1'b0;
        @(negedge clk);
        a = 16'h1111; b = 16'h2222; signed_mode = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({out_valid, resultado, borrow, overflow, zero, negative} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs got v%b %h %b%b%b%b want 0", out_valid, resultado,
                     borrow, overflow, zero, negative);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_in_ready got %b want 1", in_ready);
        end
        repeat (8) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1'b1;
        end
        n_checks++;
        if (saw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_no_result got %b want 0", saw_valid);
        end
        do_op(16'h0005, 16'h0003, 1'b0, 0, r, f, lat);
        n_checks++;
        if ({r, f} !== {16'h0002, 4'b0000}) begin
            n_fail++;
            $display("FAIL midrst_next_op got %h/%b want 0002/0000", r, f);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] x, y, r, er;
        logic [3:0]    f, ef;
        logic          sm;
        int            lat;
        for (int i = 0; i < 60; i++) begin
            x  = pick_operand();
            y  = pick_operand();
            sm = 1'($urandom);
            model(x, y, sm, er, ef);
            do_op(x, y, sm, int'($urandom_range(0, 3)), r, f, lat);
            n_checks++;
            if ({r, f} !== {er, ef} || lat !== int'(N)) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h s=%b got %h/%b lat %0d want %h/%b lat %0d",
                         i, x, y, sm, r, f, lat, er, ef, N);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_r [$];
        logic [3:0]    exp_f [$];
        int            acc_c [$];
        logic [DW-1:0] er;
        logic [3:0]    ef;
        int            last_acc = -1;
        int            c_acc;
        int            n_acc = 0;
        a = pick_operand(); b = pick_operand(); signed_mode = 1'($urandom);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 52; c++) begin
            @(negedge clk);
            if (c >= 40) in_valid = 1'b0;
            if (out_valid) begin
                n_checks++;
                if (exp_r.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_unexpected_result got %h want none", resultado);
                end else begin
                    er    = exp_r.pop_front();
                    ef    = exp_f.pop_front();
                    c_acc = acc_c.pop_front();
                    if ({resultado, borrow, overflow, zero, negative} !== {er, ef}
                        || (c - c_acc) !== int'(N) + 1) begin
                        n_fail++;
                        $display("FAIL b2b_result got %h/%b after %0d want %h/%b after %0d",
                                 resultado, {borrow, overflow, zero, negative}, c - c_acc,
                                 er, ef, N + 1);
                    end
                end
            end
            if (in_ready && in_valid) begin
                model(a, b, signed_mode, er, ef);
                exp_r.push_back(er);
                exp_f.push_back(ef);
                acc_c.push_back(c);
                if (last_acc >= 0) begin
                    n_checks++;
                    if ((c - last_acc) !== int'(N) + 2) begin
                        n_fail++;
                        $display("FAIL b2b_interval got %0d want %0d", c - last_acc, N + 2);
                    end
                end
                last_acc = c;
                n_acc++;
            end
            @(posedge clk);
            #1;
            a = pick_operand(); b = pick_operand(); signed_mode = 1'($urandom);
        end
        out_ready = 1'b0;
        n_checks++;
        if (exp_r.size() !== 0 || n_acc < 5) begin
            n_fail++;
            $display("FAIL b2b_drain got pending %0d accepts %0d want 0 and >=5",
                     exp_r.size(), n_acc);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_busy();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
